encrypt_pipe_xor_rotate: RTL and testbench

//  Final encrypt pipeline stage, directly downstream of the shift/scramble stage.

---
 rtl/encrypt_pipe_xor_rotate.sv | 62 ++++++
 tb/tb_encrypt_pipe_xor_rotate.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/encrypt_pipe_xor_rotate.sv
// encrypt_pipe_xor_rotate: XOR each byte with a rolling, round-rotated key (k1->k2->k3),
// registered with one cycle of latency.
module encrypt_pipe_xor_rotate #(
    parameter int DATA_W  = 8,
    parameter int ROUND_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DATA_W-1:0] din,
    input  logic [DATA_W-1:0] k1,
    input  logic [DATA_W-1:0] k2,
    input  logic [DATA_W-1:0] k3,
    input  logic [2:0]        rot_freq,
    input  logic              mode,
    input  logic              key_load,
    output logic              en_out,
    output logic [DATA_W-1:0] data_out,
    output logic [1:0]        key_sel_out
);
    typedef enum logic [1:0] {K1 = 2'd0, K2 = 2'd1, K3 = 2'd2} key_t;

    key_t               key_sel, sel_eff, key_sel_nxt;
    logic [2:0]         cnt, cnt_eff, cnt_nxt;
    logic [ROUND_W-1:0] round, round_eff, round_nxt;
    logic [DATA_W-1:0]  k_raw, k_rot;
    logic [2*DATA_W-1:0] k_dbl;
    logic               acc, adv;

    always_comb begin
        sel_eff     = key_load ? K1 : key_sel;
        cnt_eff     = key_load ? 3'd0 : cnt;
        round_eff   = key_load ? '0 : round;
        k_raw       = sel_eff == K2 ? k2 : sel_eff == K3 ? k3 : k1;
        // Circular rotate: the upper half of the doubled key shifted left.
        k_dbl       = {k_raw, k_raw} << round_eff;
        k_rot       = k_dbl[2*DATA_W-1:DATA_W];
        acc         = en & mode;
        adv         = acc && rot_freq != 3'd0 && cnt_eff >= rot_freq - 3'd1;
        cnt_nxt     = (!acc || rot_freq == 3'd0) ? cnt_eff : adv ? 3'd0 : cnt_eff + 3'd1;
        key_sel_nxt = !adv ? sel_eff : sel_eff == K1 ? K2 : sel_eff == K2 ? K3 : K1;
        round_nxt   = (adv && sel_eff == K3) ? round_eff + 1'b1 : round_eff;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_sel  <= K1;
            cnt      <= 3'd0;
            round    <= '0;
            en_out   <= 1'b0;
            data_out <= '0;
        end else begin
            key_sel  <= key_sel_nxt;
            cnt      <= cnt_nxt;
            round    <= round_nxt;
            en_out   <= en;
            data_out <= !en ? '0 : mode ? din ^ k_rot : din;
        end
    end

    assign key_sel_out = key_sel;
endmodule

// File: tb/tb_encrypt_pipe_xor_rotate.sv
// tb_encrypt_pipe_xor_rotate: vector tables feed a scoreboard queue checked one cycle later,
// plus hand-written sequences for async reset.
module tb_encrypt_pipe_xor_rotate;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0, mode = 1'b1, key_load = 1'b0;
    logic [7:0] din = 8'h00, k1 = 8'h0F, k2 = 8'hF0, k3 = 8'h55;
    logic [2:0] rot_freq = 3'd2;
    logic       en_out;
    logic [7:0] data_out;
    logic [1:0] key_sel_out;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       e, m, kl;
        logic [7:0] d;
        logic [2:0] rf;
        logic [7:0] kk1;
        logic       ee;
        logic [7:0] ed;
        logic [1:0] es;
    } vec_t;

    typedef struct {
        logic       e;
        logic [7:0] d;
        logic [1:0] s;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    encrypt_pipe_xor_rotate #(.DATA_W(8), .ROUND_W(3)) dut (
        .clk(clk), .rst(rst), .en(en), .din(din), .k1(k1), .k2(k2), .k3(k3),
        .rot_freq(rot_freq), .mode(mode), .key_load(key_load),
        .en_out(en_out), .data_out(data_out), .key_sel_out(key_sel_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_out(input string name);
        exp_t x;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty, got en_out=%b data_out=%h", name, en_out, data_out);
        end else begin
            x = sb.pop_front();
            chk({name, ".en_out"}, {7'd0, en_out}, {7'd0, x.e});
            chk({name, ".data_out"}, data_out, x.d);
            chk({name, ".key_sel"}, {6'd0, key_sel_out}, {6'd0, x.s});
        end
    endtask

    task automatic add(input logic e, input logic m, input logic kl, input logic [7:0] d,
                       input logic [2:0] rf, input logic [7:0] kk1,
                       input logic ee, input logic [7:0] ed, input logic [1:0] es);
        vecs.push_back('{e, m, kl, d, rf, kk1, ee, ed, es});
    endtask

    task automatic run_vecs(input string tag);
        foreach (vecs[i]) begin
            @(negedge clk);
            en = vecs[i].e; mode = vecs[i].m; key_load = vecs[i].kl;
            din = vecs[i].d; rot_freq = vecs[i].rf; k1 = vecs[i].kk1;
            sb.push_back('{vecs[i].ee, vecs[i].ed, vecs[i].es});
            @(posedge clk);
            #1 check_out($sformatf("%s[%0d]", tag, i));
        end
        vecs.delete();
        @(negedge clk);
        en = 1'b0; key_load = 1'b0; mode = 1'b1;
    endtask

    task automatic apply_reset(input string tag);
        @(negedge clk);
        rst = 1'b0; en = 1'b0; key_load = 1'b0; mode = 1'b1;
        @(posedge clk);
        #1;
        chk({tag, ".rst_en_out"}, {7'd0, en_out}, 8'h00);
        chk({tag, ".rst_data"}, data_out, 8'h00);
        chk({tag, ".rst_sel"}, {6'd0, key_sel_out}, 8'h00);
        @(negedge clk);
        rst = 1'b1;
    endtask

    function automatic logic [7:0] rotl(input logic [7:0] x, input int r);
        logic [7:0] y = x;
        for (int j = 0; j < r; j++) y = {y[6:0], y[7]};
        return y;
    endfunction

    task automatic add_t1();
        add(1, 1, 0, 8'h00, 3'd2, 8'h0F, 1, 8'h0F, 2'd0);
        add(1, 1, 0, 8'h00, 3'd2, 8'h0F, 1, 8'h0F, 2'd1);
        add(1, 1, 0, 8'h00, 3'd2, 8'h0F, 1, 8'hF0, 2'd1);
        add(1, 1, 0, 8'h00, 3'd2, 8'h0F, 1, 8'hF0, 2'd2);
        add(1, 1, 0, 8'h00, 3'd2, 8'h0F, 1, 8'h55, 2'd2);
        add(1, 1, 0, 8'h00, 3'd2, 8'h0F, 1, 8'h55, 2'd0);
        add(1, 1, 0, 8'h00, 3'd2, 8'h0F, 1, 8'h1E, 2'd0);
    endtask

    initial begin
        apply_reset("init");

        add_t1();
        run_vecs("t1");

        apply_reset("r2");
        for (int i = 0; i < 5; i++) add(1, 1, 0, 8'hAA, 3'd0, 8'h0F, 1, 8'hA5, 2'd0);
        run_vecs("t2");

        apply_reset("r3");
        add(1, 1, 0, 8'h00, 3'd2, 8'h0F, 1, 8'h0F, 2'd0);
        add(1, 1, 0, 8'h00, 3'd2, 8'h0F, 1, 8'h0F, 2'd1);
        add(0, 1, 0, 8'h77, 3'd2, 8'h0F, 0, 8'h00, 2'd1);
        add(0, 1, 0, 8'h77, 3'd2, 8'h0F, 0, 8'h00, 2'd1);
        add(1, 1, 0, 8'h00, 3'd2, 8'h0F, 1, 8'hF0, 2'd1);
        add(1, 0, 0, 8'h3C, 3'd2, 8'h0F, 1, 8'h3C, 2'd1);
        add(1, 1, 0, 8'h00, 3'd2, 8'h0F, 1, 8'hF0, 2'd2);
        add(1, 1, 0, 8'h00, 3'd2, 8'h0F, 1, 8'h55, 2'd2);
        run_vecs("t3");

        apply_reset("r4");
        add(1, 1, 0, 8'h00, 3'd2, 8'h0F, 1, 8'h0F, 2'd0);
        add(1, 1, 0, 8'h00, 3'd2, 8'h0F, 1, 8'h0F, 2'd1);
        add(1, 1, 0, 8'h00, 3'd2, 8'h0F, 1, 8'hF0, 2'd1);
        add(1, 1, 1, 8'h00, 3'd2, 8'h0F, 1, 8'h0F, 2'd0);
        add(1, 1, 0, 8'h00, 3'd2, 8'h0F, 1, 8'h0F, 2'd1);
        add(1, 1, 0, 8'h00, 3'd2, 8'h0F, 1, 8'hF0, 2'd1);
        add(0, 1, 1, 8'h00, 3'd2, 8'h0F, 0, 8'h00, 2'd0);
        add(1, 1, 0, 8'h00, 3'd2, 8'h0F, 1, 8'h0F, 2'd0);
        run_vecs("t4");

        // Every byte advances; byte i sits on key i%3 in round i/3 (mod 8).
        apply_reset("r5");
        for (int i = 0; i < 25; i++) begin
            logic [7:0] kb;
            kb = (i % 3 == 0) ? 8'h01 : (i % 3 == 1) ? 8'hF0 : 8'h55;
            add(1, 1, 0, 8'h00, 3'd1, 8'h01, 1, rotl(kb, (i / 3) % 8), 2'((i + 1) % 3));
        end
        run_vecs("t5");

        apply_reset("r6");
        add_t1();
        run_vecs("t6");
        @(negedge clk);
        en = 1'b1; din = 8'h00;
        sb.push_back('{1'b1, 8'h1E, 2'd1});
        @(posedge clk);
        #1 check_out("t6.pre");
        #2 rst = 1'b0;
        #1;
        chk("t6.async_en_out", {7'd0, en_out}, 8'h00);
        chk("t6.async_data", data_out, 8'h00);
        chk("t6.async_sel", {6'd0, key_sel_out}, 8'h00);
        @(negedge clk);
        en = 1'b0;
        rst = 1'b1;
        add(1, 1, 0, 8'h00, 3'd2, 8'h0F, 1, 8'h0F, 2'd0);
        run_vecs("t6.post");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
